seq_detect_1011: RTL and testbench

SEQ_DETECT_1011 -- requirements
Module: seq_detect_1011

---
 rtl/seq_detect_pkg.sv | 28 ++
 rtl/sat_counter.sv | 26 ++
 rtl/seq_detect_1011.sv | 62 ++++++
 tb/tb_seq_detect_1011.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared state encoding, pattern constant and next-state function for the 1011 detector.
package seq_detect_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StG1   = 3'd1,
    StG10  = 3'd2,
    StG101 = 3'd3,
    StHit  = 3'd4
  } state_e;

  localparam logic [3:0] Pattern = 4'b1011;

  // Overlapping MSB-first search; unused codes fall back to idle.
  function automatic state_e next_state(input state_e cur, input logic din);
    state_e nxt;
    case (cur)
      StIdle:  nxt = (din == Pattern[3]) ? StG1   : StIdle;
      StG1:    nxt = (din == Pattern[2]) ? StG10  : StG1;
      StG10:   nxt = (din == Pattern[1]) ? StG101 : StIdle;
      StG101:  nxt = (din == Pattern[0]) ? StHit  : StG10;
      StHit:   nxt = din ? StG1 : StG10;
      default: nxt = StIdle;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Clr,
  input  logic             Inc,
  output logic [CNT_W-1:0] Count
);

  localparam logic [CNT_W-1:0] MaxVal = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge Clk) begin
    if (Rst || Clr) begin
      count_q <= '0;
    end else if (Inc && (count_q != MaxVal)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign Count = count_q;

endmodule

// File: rtl/seq_detect_1011.sv
// Moore detector for serial pattern 1011 with overlap and a registered one-cycle Match.
// Match counter is built only when SEQ_DETECT_COUNT_EN is defined; otherwise Count is 0.
module seq_detect_1011
  import seq_detect_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Din,
  input  logic             En,
  input  logic             Clr,
  output logic             Match,
  output logic [CNT_W-1:0] Count,
  output logic [2:0]       State
);

  state_e state_q;
  state_e state_d;
  logic   match_q;
  logic   illegal;

  assign state_d = next_state(state_q, Din);
  assign illegal = (state_q > StHit);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= StIdle;
      match_q <= 1'b0;
    end else if (En) begin
      state_q <= state_d;
      match_q <= (state_d == StHit);
    end else begin
      // Stalled edge: hold state, but never repeat a Match pulse.
      state_q <= illegal ? StIdle : state_q;
      match_q <= 1'b0;
    end
  end

  assign Match = match_q;
  assign State = state_q;

`ifdef SEQ_DETECT_COUNT_EN
  logic inc;
  assign inc = En && (state_d == StHit);

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_sat_counter (
    .Clk   (Clk),
    .Rst   (Rst),
    .Clr   (Clr),
    .Inc   (inc),
    .Count (Count)
  );
`else
  logic unused_clr;
  assign unused_clr = Clr;
  assign Count      = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_detect_1011.sv
// Directed self-checking bench for seq_detect_1011 (8-bit and 2-bit counter instances).
module tb_seq_detect_1011;

`ifdef SEQ_DETECT_COUNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Din = 1'b0;
  logic       En  = 1'b0;
  logic       Clr = 1'b0;
  logic       match_a;
  logic [7:0] count_a;
  logic [2:0] state_a;
  logic       match_b;
  logic [1:0] count_b;
  logic [2:0] state_b;

  int n_total = 0;
  int n_bad   = 0;

  always #5 Clk = ~Clk;

  seq_detect_1011 #(.CNT_W(8)) u_dut_a (
    .Clk   (Clk),
    .Rst   (Rst),
    .Din   (Din),
    .En    (En),
    .Clr   (Clr),
    .Match (match_a),
    .Count (count_a),
    .State (state_a)
  );

  seq_detect_1011 #(.CNT_W(2)) u_dut_b (
    .Clk   (Clk),
    .Rst   (Rst),
    .Din   (Din),
    .En    (En),
    .Clr   (Clr),
    .Match (match_b),
    .Count (count_b),
    .State (state_b)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_cnt(input int n);
    return CntEn ? n : 0;
  endfunction

  // Apply one edge's worth of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic din, input logic en, input logic clr, input logic rst);
    Din = din;
    En  = en;
    Clr = clr;
    Rst = rst;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic run_bits(input string tag, input logic [31:0] bits, input int n,
                          input logic [31:0] exp_m);
    for (int i = n - 1; i >= 0; i--) begin
      step(bits[i], 1'b1, 1'b0, 1'b0);
      check_eq($sformatf("%s_m%0d", tag, n - 1 - i), int'(match_a), int'(exp_m[i]));
    end
  endtask

  initial begin
    // Reset overrides En/Din/Clr
    do_reset();
    check_eq("rst_state", int'(state_a), 0);
    check_eq("rst_match", int'(match_a), 0);
    check_eq("rst_count", int'(count_a), 0);

    // Single 1011
    run_bits("one", 32'b1011, 4, 32'b0001);
    check_eq("one_state", int'(state_a), 4);
    check_eq("one_count", int'(count_a), exp_cnt(1));

    // 1011011: matches after bits 4 and 7
    do_reset();
    run_bits("ovl", 32'b1011011, 7, 32'b0001001);
    check_eq("ovl_count", int'(count_a), exp_cnt(2));

    // 10111011: two matches
    do_reset();
    run_bits("ovl2", 32'b10111011, 8, 32'b00010001);
    check_eq("ovl2_count", int'(count_a), exp_cnt(2));

    // Stall with En=0 while Din toggles
    do_reset();
    run_bits("stl_a", 32'b10, 2, 32'b00);
    for (int i = 0; i < 3; i++) begin
      step(i[0] ? 1'b0 : 1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("stl_hold_state", int'(state_a), 2);
      check_eq("stl_hold_match", int'(match_a), 0);
    end
    run_bits("stl_b", 32'b11, 2, 32'b01);
    check_eq("stl_count", int'(count_a), exp_cnt(1));

    // Match held in HIT then stalled: pulse lasts one cycle only
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("hit_stall_match", int'(match_a), 0);
    check_eq("hit_stall_state", int'(state_a), 4);
    check_eq("hit_stall_count", int'(count_a), exp_cnt(1));

    // Saturation: five back-to-back 1011
    do_reset();
    for (int r = 1; r <= 5; r++) begin
      run_bits("sat", 32'b1011, 4, 32'b0001);
      check_eq($sformatf("sat_a_%0d", r), int'(count_a), exp_cnt(r));
      check_eq($sformatf("sat_b_%0d", r), int'(count_b), exp_cnt(r > 3 ? 3 : r));
    end

    // Clear on the match edge: Count cleared, Match still pulses
    do_reset();
    run_bits("clr_pre", 32'b1011, 4, 32'b0001);
    check_eq("clr_pre_count", int'(count_a), exp_cnt(1));
    run_bits("clr_mid", 32'b01, 2, 32'b00);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("clr_match", int'(match_a), 1);
    check_eq("clr_state", int'(state_a), 4);
    check_eq("clr_count", int'(count_a), 0);
    check_eq("clr_count_b", int'(count_b), 0);

    // Reset mid-pattern discards history
    do_reset();
    run_bits("rmid", 32'b101, 3, 32'b000);
    check_eq("rmid_state_pre", int'(state_a), 3);
    do_reset();
    check_eq("rmid_state_rst", int'(state_a), 0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("rmid_match", int'(match_a), 0);
    check_eq("rmid_state", int'(state_a), 1);
    check_eq("rmid_count", int'(count_a), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
